// File: rtl/dma_master_pkg.sv
// dma_master_pkg: shared bus widths and FSM state encodings for the DMA
// bus initiator. Imported by dma_master.
package dma_master_pkg;

    localparam int BUS_ADDR_WIDTH = 16;
    localparam int DATA_WIDTH     = 16;

    typedef enum logic [2:0] {
        DMA_IDLE = 3'd0,
        DMA_RD   = 3'd1,
        DMA_CAP  = 3'd2,
        DMA_WR   = 3'd3,
        DMA_DONE = 3'd4
    } dma_state_e;

endpackage

// File: rtl/dma_master.sv
// dma_master: bus initiator that copies a block of len words from a source
// bus address to a destination bus address, one word read then written at
// a time, in ascending order (3 cycles per word).
//
// Ports:
//   clk      in   system clock, rising edge
//   reset_   in   asynchronous active-low reset
//   start    in   one-cycle transfer request, sampled in IDLE only
//   src      in   first source word address (captured on start)
//   dst      in   first destination word address (captured on start)
//   len      in   word count (captured on start); 0 gives an immediate done
//   busy     out  transfer in progress (RD/CAP/WR)
//   done     out  one-cycle completion pulse
//   addr     out  bus address to the slaves
//   wdata    out  write data to the slaves
//   rdata    in   slave read data, valid the cycle after the address
//   rw_      out  1 = read, 0 = write
//
// State | meaning
// ------+---------------------------------------------------------------
// IDLE  | bus parked (addr=0, wdata=0, rw_=1), waiting for start
// RD    | read address src+i presented
// CAP   | address held; slave data captured into the buffer at cycle end
// WR    | write buffer to dst+i; slave commits at cycle end
// DONE  | done pulse for one cycle, bus parked
module dma_master
    import dma_master_pkg::*;
#(
    parameter int LEN_WIDTH = 8
) (
    input  logic                      clk,
    input  logic                      reset_,
    input  logic                      start,
    input  logic [BUS_ADDR_WIDTH-1:0] src,
    input  logic [BUS_ADDR_WIDTH-1:0] dst,
    input  logic [LEN_WIDTH-1:0]      len,
    output logic                      busy,
    output logic                      done,
    output logic [BUS_ADDR_WIDTH-1:0] addr,
    output logic [DATA_WIDTH-1:0]     wdata,
    input  logic [DATA_WIDTH-1:0]     rdata,
    output logic                      rw_
);

    dma_state_e                state_q, state_d;
    logic [BUS_ADDR_WIDTH-1:0] src_q, src_d;
    logic [BUS_ADDR_WIDTH-1:0] dst_q, dst_d;
    logic [LEN_WIDTH-1:0]      len_q, len_d;
    logic [LEN_WIDTH-1:0]      i_q, i_d;
    logic [LEN_WIDTH-1:0]      i_inc;
    logic [DATA_WIDTH-1:0]     buffer_q, buffer_d;
    logic [BUS_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0]     wdata_q, wdata_d;
    logic                      rw_q, rw_d;
    logic                      busy_q, busy_d;
    logic                      done_q, done_d;

    assign i_inc = i_q + 1'b1;

    // Bus outputs are computed for the state being entered and registered,
    // so nothing on the bus is combinational from the inputs.
    always_comb begin
        state_d  = state_q;
        src_d    = src_q;
        dst_d    = dst_q;
        len_d    = len_q;
        i_d      = i_q;
        buffer_d = buffer_q;
        addr_d   = '0;
        wdata_d  = '0;
        rw_d     = 1'b1;
        busy_d   = 1'b0;
        done_d   = 1'b0;

        unique case (state_q)
            DMA_IDLE: begin
                if (start) begin
                    if (len != '0) begin
                        src_d   = src;
                        dst_d   = dst;
                        len_d   = len;
                        i_d     = '0;
                        state_d = DMA_RD;
                        addr_d  = src;
                        busy_d  = 1'b1;
                    end else begin
                        state_d = DMA_DONE;
                        done_d  = 1'b1;
                    end
                end
            end
            DMA_RD: begin
                state_d = DMA_CAP;
                addr_d  = addr_q;
                busy_d  = 1'b1;
            end
            DMA_CAP: begin
                buffer_d = rdata;
                state_d  = DMA_WR;
                addr_d   = dst_q + BUS_ADDR_WIDTH'(i_q);
                wdata_d  = rdata;
                rw_d     = 1'b0;
                busy_d   = 1'b1;
            end
            DMA_WR: begin
                if (i_q == len_q - 1'b1) begin
                    state_d = DMA_DONE;
                    done_d  = 1'b1;
                end else begin
                    i_d     = i_inc;
                    state_d = DMA_RD;
                    addr_d  = src_q + BUS_ADDR_WIDTH'(i_inc);
                    busy_d  = 1'b1;
                end
            end
            DMA_DONE: begin
                state_d = DMA_IDLE;
            end
            default: begin
                state_d = DMA_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            state_q  <= DMA_IDLE;
            src_q    <= '0;
            dst_q    <= '0;
            len_q    <= '0;
            i_q      <= '0;
            buffer_q <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rw_q     <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            src_q    <= src_d;
            dst_q    <= dst_d;
            len_q    <= len_d;
            i_q      <= i_d;
            buffer_q <= buffer_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rw_q     <= rw_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign addr  = addr_q;
    assign wdata = wdata_q;
    assign rw_   = rw_q;
    assign busy  = busy_q;
    assign done  = done_q;

endmodule
